// File: rtl/hub75_rx.sv
// HUB75 panel-bus receiver: captures shifted pixel lines into ping-pong line
// buffers and replays each latched line as a valid/ready word stream on CLK.
module hub75_rx #(
    parameter int COLS = 64
) (
    input  logic       CLK,
    input  logic       resetn,
    input  logic       SCLK,
    input  logic       LATCH,
    input  logic       BLANK,
    input  logic [4:0] ADDR,
    input  logic [2:0] RGB0,
    input  logic [2:0] RGB1,
    output logic       px_valid,
    input  logic       px_ready,
    output logic [5:0] px_data,
    output logic [5:0] px_col,
    output logic [4:0] px_row,
    output logic       px_last,
    output logic [6:0] line_len,
    output logic       ovf,
    output logic       blank_s
);

    localparam int         IW       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [6:0] COLS_W   = 7'(COLS);
    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [6:0] EDGE_MAX = 7'd127;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    logic       sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic       latch_meta_q, latch_sync_q, latch_prev_q;
    logic       blank_meta_q, blank_sync_q;
    logic [4:0] addr_meta_q, addr_sync_q;
    logic [5:0] rgb_meta_q, rgb_sync_q;

    logic [6:0] col_cnt_q, col_cnt_d;
    logic [6:0] edge_cnt_q, edge_cnt_d;
    logic       fill_sel_q, fill_sel_d;
    logic       ovf_q, ovf_d;

    state_t     state_q, state_d;
    logic       px_valid_q, px_valid_d;
    logic [5:0] px_data_q, px_data_d;
    logic [5:0] px_col_q, px_col_d;
    logic [4:0] px_row_q, px_row_d;
    logic       px_last_q, px_last_d;
    logic [6:0] line_len_q, line_len_d;

    logic [5:0] mem_q [2][COLS];

    logic       sclk_rise_s, latch_rise_s, wr_en_s;
    logic       accept_s, drain_free_s, commit_s;
    logic [IW-1:0] wr_idx_s;
    logic [6:0] edge_inc_s;
    logic [5:0] head_pix_s, rd_pix_s, rd_col_s;

    // Two-flop synchronizers plus previous-value flops for edge detection
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            sclk_meta_q  <= 1'b0;
            sclk_sync_q  <= 1'b0;
            sclk_prev_q  <= 1'b0;
            latch_meta_q <= 1'b0;
            latch_sync_q <= 1'b0;
            latch_prev_q <= 1'b0;
            blank_meta_q <= 1'b0;
            blank_sync_q <= 1'b0;
            addr_meta_q  <= 5'd0;
            addr_sync_q  <= 5'd0;
            rgb_meta_q   <= 6'd0;
            rgb_sync_q   <= 6'd0;
        end else begin
            sclk_meta_q  <= SCLK;
            sclk_sync_q  <= sclk_meta_q;
            sclk_prev_q  <= sclk_sync_q;
            latch_meta_q <= LATCH;
            latch_sync_q <= latch_meta_q;
            latch_prev_q <= latch_sync_q;
            blank_meta_q <= BLANK;
            blank_sync_q <= blank_meta_q;
            addr_meta_q  <= ADDR;
            addr_sync_q  <= addr_meta_q;
            rgb_meta_q   <= {RGB1, RGB0};
            rgb_sync_q   <= rgb_meta_q;
        end
    end

    assign sclk_rise_s  = sclk_sync_q & ~sclk_prev_q;
    assign latch_rise_s = latch_sync_q & ~latch_prev_q;
    assign wr_en_s      = sclk_rise_s & (col_cnt_q < COLS_W);
    assign wr_idx_s     = col_cnt_q[IW-1:0];
    assign edge_inc_s   = (sclk_rise_s && (edge_cnt_q != EDGE_MAX)) ? edge_cnt_q + 7'd1 : edge_cnt_q;
    assign accept_s     = px_valid_q & px_ready;
    // The drain is free either when idle or when its last word leaves this very cycle
    assign drain_free_s = (state_q == IDLE) | (accept_s & px_last_q);
    assign commit_s     = latch_rise_s & drain_free_s;

    // A pixel landing on column 0 in the commit cycle is forwarded past the buffer
    assign head_pix_s = (wr_en_s && (col_cnt_q == 7'd0)) ? rgb_sync_q : mem_q[fill_sel_q][IW'(0)];
    assign rd_col_s   = px_col_q + 6'd1;
    assign rd_pix_s   = mem_q[~fill_sel_q][rd_col_s[IW-1:0]];

    // Line buffer write port; contents are deliberately left unreset
    always_ff @(posedge CLK) begin
        if (wr_en_s) begin
            mem_q[fill_sel_q][wr_idx_s] <= rgb_sync_q;
        end
    end

    // Fill-side next state: column/edge counters, buffer select, overflow
    always_comb begin
        col_cnt_d  = col_cnt_q;
        edge_cnt_d = edge_cnt_q;
        fill_sel_d = fill_sel_q;
        ovf_d      = ovf_q;
        if (latch_rise_s) begin
            col_cnt_d  = 7'd0;
            edge_cnt_d = 7'd0;
            if (commit_s) begin
                fill_sel_d = ~fill_sel_q;
            end else begin
                ovf_d = 1'b1;
            end
        end else begin
            edge_cnt_d = edge_inc_s;
            if (wr_en_s) begin
                col_cnt_d = col_cnt_q + 7'd1;
            end else begin
                col_cnt_d = col_cnt_q;
            end
        end
    end

    // Fill-side state registers
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            col_cnt_q  <= 7'd0;
            edge_cnt_q <= 7'd0;
            fill_sel_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            col_cnt_q  <= col_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            fill_sel_q <= fill_sel_d;
            ovf_q      <= ovf_d;
        end
    end

    // Drain FSM next state and registered word outputs
    always_comb begin
        state_d    = state_q;
        px_valid_d = px_valid_q;
        px_data_d  = px_data_q;
        px_col_d   = px_col_q;
        px_row_d   = px_row_q;
        px_last_d  = px_last_q;
        line_len_d = line_len_q;
        case (state_q)
            IDLE: begin
                if (commit_s) begin
                    state_d    = SEND;
                    px_valid_d = 1'b1;
                    px_col_d   = 6'd0;
                    px_last_d  = (LAST_COL == 6'd0);
                    px_row_d   = addr_sync_q;
                    line_len_d = edge_inc_s;
                    px_data_d  = (edge_inc_s != 7'd0) ? head_pix_s : 6'd0;
                end else begin
                    px_valid_d = 1'b0;
                end
            end
            SEND: begin
                if (accept_s && px_last_q) begin
                    if (commit_s) begin
                        px_valid_d = 1'b1;
                        px_col_d   = 6'd0;
                        px_last_d  = (LAST_COL == 6'd0);
                        px_row_d   = addr_sync_q;
                        line_len_d = edge_inc_s;
                        px_data_d  = (edge_inc_s != 7'd0) ? head_pix_s : 6'd0;
                    end else begin
                        state_d    = IDLE;
                        px_valid_d = 1'b0;
                        px_last_d  = 1'b0;
                    end
                end else if (accept_s) begin
                    px_col_d  = rd_col_s;
                    px_last_d = (rd_col_s == LAST_COL);
                    px_data_d = ({1'b0, rd_col_s} < line_len_q) ? rd_pix_s : 6'd0;
                end else begin
                    px_valid_d = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                px_valid_d = 1'b0;
                px_last_d  = 1'b0;
            end
        endcase
    end

    // Drain FSM and output registers
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            px_valid_q <= 1'b0;
            px_data_q  <= 6'd0;
            px_col_q   <= 6'd0;
            px_row_q   <= 5'd0;
            px_last_q  <= 1'b0;
            line_len_q <= 7'd0;
        end else begin
            state_q    <= state_d;
            px_valid_q <= px_valid_d;
            px_data_q  <= px_data_d;
            px_col_q   <= px_col_d;
            px_row_q   <= px_row_d;
            px_last_q  <= px_last_d;
            line_len_q <= line_len_d;
        end
    end

    assign px_valid = px_valid_q;
    assign px_data  = px_data_q;
    assign px_col   = px_col_q;
    assign px_row   = px_row_q;
    assign px_last  = px_last_q;
    assign line_len = line_len_q;
    assign ovf      = ovf_q;
    assign blank_s  = blank_sync_q;

endmodule

// File: tb/tb_hub75_rx.sv
// Directed bench for hub75_rx: shifts panel lines in and checks the replayed
// word stream, stalls, overflow, short/long lines and mid-line reset.
module tb_hub75_rx;

    logic       CLK = 1'b0;
    logic       resetn = 1'b0;
    logic       SCLK = 1'b0;
    logic       LATCH = 1'b0;
    logic       BLANK = 1'b0;
    logic [4:0] ADDR = 5'd0;
    logic [2:0] RGB0 = 3'd0;
    logic [2:0] RGB1 = 3'd0;
    logic       px_ready = 1'b0;
    logic       px_valid;
    logic [5:0] px_data;
    logic [5:0] px_col;
    logic [4:0] px_row;
    logic       px_last;
    logic [6:0] line_len;
    logic       ovf;
    logic       blank_s;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [17:0] words [$];
    bit          toggle_en = 1'b0;
    logic        stall_q = 1'b0;
    logic [16:0] stall_word = 17'd0;

    hub75_rx #(.COLS(64)) dut (
        .CLK(CLK), .resetn(resetn), .SCLK(SCLK), .LATCH(LATCH), .BLANK(BLANK),
        .ADDR(ADDR), .RGB0(RGB0), .RGB1(RGB1), .px_valid(px_valid), .px_ready(px_ready),
        .px_data(px_data), .px_col(px_col), .px_row(px_row), .px_last(px_last),
        .line_len(line_len), .ovf(ovf), .blank_s(blank_s)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] pix(input int pat, input int c);
        logic [7:0] cv;
        cv = 8'(c);
        case (pat)
            0:       return (c < 64) ? {~cv[2:0], cv[2:0]} : 6'h3F;
            1:       return {cv[2:0], cv[5:3]};
            default: return cv[5:0] ^ 6'h2A;
        endcase
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic shift_line(input int n, input logic [4:0] addr, input int pat);
        ADDR = addr;
        for (int c = 0; c < n; c++) begin
            logic [5:0] p;
            p = pix(pat, c);
            {RGB1, RGB0} = p;
            cyc(2);
            SCLK = 1'b1;
            cyc(3);
            SCLK = 1'b0;
            cyc(1);
        end
    endtask

    task automatic pulse_latch();
        LATCH = 1'b1;
        cyc(3);
        LATCH = 1'b0;
        cyc(3);
    endtask

    task automatic wait_words(input int n, input string tag);
        int t;
        t = 0;
        while (words.size() < n && t < 3000) begin
            cyc(1);
            t++;
        end
        cyc(10);
        check_eq({tag, "_count"}, words.size(), n);
    endtask

    task automatic check_line(input int base, input int nsclk, input logic [4:0] addr,
                              input int pat, input string tag);
        for (int c = 0; c < 64; c++) begin
            logic [5:0]  d;
            logic [17:0] got;
            logic [17:0] exp;
            d   = (c < nsclk) ? pix(pat, c) : 6'd0;
            exp = {(c == 63), addr, 6'(c), d};
            got = (base + c < words.size()) ? words[base + c] : 18'bx;
            check_eq(tag, got, exp);
        end
    endtask

    // Monitor: records accepted words and checks outputs hold during stalls
    initial begin
        forever begin
            @(negedge CLK);
            if (resetn && stall_q) begin
                check_eq("stall", {px_valid, px_row, px_col, px_data}, {1'b1, stall_word});
            end
            stall_q    = resetn & px_valid & ~px_ready;
            stall_word = {px_row, px_col, px_data};
            if (resetn && px_valid && px_ready) begin
                words.push_back({px_last, px_row, px_col, px_data});
            end
        end
    end

    // Ready toggler for the back-pressure scenario
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (toggle_en) px_ready = ~px_ready;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        check_eq("rst_valid", px_valid, 1'b0);
        check_eq("rst_word", {px_data, px_col, px_row, px_last}, 18'd0);
        check_eq("rst_len", line_len, 7'd0);
        check_eq("rst_flags", {ovf, blank_s}, 2'b00);
        resetn = 1'b1;
        cyc(2);

        BLANK = 1'b1;
        cyc(3);
        check_eq("blank_hi", blank_s, 1'b1);
        BLANK = 1'b0;
        cyc(3);
        check_eq("blank_lo", blank_s, 1'b0);

        // Full line, always ready, with commit-to-valid latency
        px_ready = 1'b1;
        words.delete();
        shift_line(64, 5'd5, 0);
        LATCH = 1'b1;
        cyc(2);
        check_eq("lat_pre", px_valid, 1'b0);
        cyc(1);
        check_eq("lat_post", px_valid, 1'b1);
        cyc(1);
        LATCH = 1'b0;
        cyc(3);
        wait_words(64, "l31");
        check_line(0, 64, 5'd5, 0, "l31");
        check_eq("l31_len", line_len, 7'd64);

        // Ready toggling every cycle
        words.delete();
        shift_line(64, 5'd9, 1);
        toggle_en = 1'b1;
        pulse_latch();
        wait_words(64, "l32");
        toggle_en = 1'b0;
        cyc(1);
        px_ready = 1'b1;
        check_line(0, 64, 5'd9, 1, "l32");

        // Second line shifted while the first drains
        words.delete();
        shift_line(64, 5'd1, 2);
        pulse_latch();
        shift_line(64, 5'd2, 0);
        pulse_latch();
        wait_words(128, "l33");
        check_line(0, 64, 5'd1, 2, "l33a");
        check_line(64, 64, 5'd2, 0, "l33b");
        check_eq("l33_ovf", ovf, 1'b0);

        // Short line then over-long line
        words.delete();
        shift_line(40, 5'd7, 2);
        pulse_latch();
        wait_words(64, "l35s");
        check_line(0, 40, 5'd7, 2, "l35s");
        check_eq("l35s_len", line_len, 7'd40);
        words.delete();
        shift_line(70, 5'd8, 0);
        pulse_latch();
        wait_words(64, "l35l");
        check_line(0, 70, 5'd8, 0, "l35l");
        check_eq("l35l_len", line_len, 7'd70);

        // Overflow: second latch while the first line is stuck
        words.delete();
        px_ready = 1'b0;
        shift_line(64, 5'd3, 1);
        pulse_latch();
        check_eq("l34_valid", px_valid, 1'b1);
        check_eq("l34_ovf0", ovf, 1'b0);
        shift_line(8, 5'd4, 2);
        pulse_latch();
        check_eq("l34_ovf1", ovf, 1'b1);
        px_ready = 1'b1;
        wait_words(64, "l34");
        check_line(0, 64, 5'd3, 1, "l34");
        check_eq("l34_ovf_sticky", ovf, 1'b1);
        check_eq("l34_len", line_len, 7'd64);

        // Reset in the middle of a line
        words.delete();
        px_ready = 1'b0;
        shift_line(16, 5'd10, 2);
        pulse_latch();
        check_eq("l36_valid_pre", px_valid, 1'b1);
        resetn = 1'b0;
        #1;
        check_eq("l36_valid_rst", px_valid, 1'b0);
        check_eq("l36_ovf_rst", ovf, 1'b0);
        cyc(2);
        resetn = 1'b1;
        cyc(2);
        px_ready = 1'b1;
        shift_line(64, 5'd11, 1);
        pulse_latch();
        wait_words(64, "l36");
        check_line(0, 64, 5'd11, 1, "l36");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hub75_rx.md
HUB75_RX -- requirements
Module: hub75_rx

Interface
REQ-001 SHALL have parameter COLS, default 64, meaning pixels shifted per line (power of two, 2..64).
REQ-002 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port SCLK  input  1  panel shift clock, asynchronous to CLK.
REQ-005 SHALL have port LATCH  input  1  panel latch strobe, asynchronous.
REQ-006 SHALL have port BLANK  input  1  panel blank (output enable, high = dark), asynchronous.
REQ-007 SHALL have port ADDR  input  5  row-pair address, asynchronous.
REQ-008 SHALL have ports RGB0, RGB1  input  3 each  upper/lower half pixel data {B,G,R}, asynchronous.
REQ-009 SHALL have port px_valid  output  1  pixel word available.
REQ-010 SHALL have port px_ready  input  1  consumer accepts the word when high with px_valid.
REQ-011 SHALL have port px_data  output  6  {RGB1,RGB0} of one column.
REQ-012 SHALL have port px_col  output  6  column index; px_row  output  5  latched ADDR; px_last  output  1  high on column COLS-1.
REQ-013 SHALL have port line_len  output  7  SCLK rising edges counted in the last committed line.
REQ-014 SHALL have port ovf  output  1  sticky overflow flag; blank_s  output  1  synchronized BLANK.

Function
REQ-015 SHALL pass every asynchronous input through a 2-FF synchronizer; all further logic uses synchronized copies only.
REQ-016 SHALL detect SCLK and LATCH rising edges from synchronized current/previous values; CLK frequency SHALL be at least 4x SCLK.
REQ-017 On each SCLK rise, SHALL store synchronized {RGB1,RGB0} into the fill line buffer at index col_cnt and increment col_cnt.
REQ-018 First pixel after a latch SHALL be column 0; col_cnt saturates at COLS, further SCLK edges discarded but still counted into line_len (saturating at 127).
REQ-019 SHALL hold two COLS x 6 line buffers in ping-pong: one filling, one draining.
REQ-020 On LATCH rise with drain buffer idle: swap buffers, capture ADDR into px_row, copy edge count into line_len, clear col_cnt and edge count.
REQ-021 On LATCH rise while drain still busy: SHALL set ovf, drop the filled line, clear col_cnt, leave the drain untouched.
REQ-022 SCLK rise and LATCH rise in the same CLK cycle: pixel SHALL be written to the old fill buffer first, then the latch commit applies.
REQ-023 Drain FSM states IDLE, SEND; IDLE->SEND on commit; px_valid SHALL assert the cycle after commit.
REQ-024 In SEND, px_col starts at 0 and increments on each px_valid & px_ready; px_data/px_col/px_row SHALL stay stable while px_valid & !px_ready.
REQ-025 SEND->IDLE on acceptance with px_last high; px_valid deasserts the next cycle; a pending commit that same cycle SHALL be accepted (no ovf).
REQ-026 Columns at or above line_len in a short line SHALL be emitted as 6'b0.
REQ-027 blank_s SHALL mirror synchronized BLANK; BLANK SHALL not affect capture.

Reset
REQ-028 resetn low SHALL asynchronously clear: px_valid=0, px_data=0, px_col=0, px_row=0, px_last=0, line_len=0, ovf=0, blank_s=0, col_cnt=0, synchronizers=0, FSM=IDLE.
REQ-029 Buffer contents need not reset; reset mid-SEND SHALL abort the line with no further px_valid.
REQ-030 ovf SHALL clear only by reset.

Verification
REQ-031 64 SCLK pulses with RGB0=col[2:0], RGB1=~col[2:0], ADDR=5, LATCH -> 64 words, px_row=5, px_data={~c,c}, px_last only at col 63, line_len=64.
REQ-032 px_ready toggled 1-0-1 on each cycle -> no word lost or duplicated, outputs stable during stalls.
REQ-033 Second line shifted and latched while first drains with px_ready=1 -> both lines delivered in order, ovf=0.
REQ-034 px_ready=0 held, two LATCH rises -> ovf=1, first line intact after release, second dropped.
REQ-035 40 SCLK then LATCH -> line_len=40, columns 40..63 emit 0; 70 SCLK -> line_len=70, columns 0..63 from first 64 pixels.
REQ-036 resetn pulsed low mid-SEND -> px_valid=0 immediately, ovf=0, next line captured correctly from column 0.
